// File: rtl/seqdet_stream_ctrl.sv
// Word-stream to serial-bit controller for a clock-enabled sequence detector; counts hits per run.
// Optional build macro SEQDET_CTRL_ABORT_EN adds an `abort` input that cancels a run.
module seqdet_stream_ctrl #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_words,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              det_x,
  output logic              det_en,
  output logic              det_rst,
  input  logic              det_y,
  output logic [CNT_W-1:0]  match_count,
  output logic              match_pulse,
  output logic              busy,
  output logic              done
`ifdef SEQDET_CTRL_ABORT_EN
  ,
  input  logic              abort
`endif
);

  // state   | meaning
  // S_IDLE  | waiting for start
  // S_CLEAR | detector clear, match_count reset
  // S_LOAD  | waiting for an input word (underrun stall)
  // S_SHIFT | one bit per cycle onto det_x
  // S_DRAIN | last detector output sampled
  // S_DONE  | one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_SHIFT, S_DRAIN, S_DONE
  } state_t;

  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  shreg_q;
  logic [BIT_W-1:0]   bit_cnt_q;
  logic [CNT_W-1:0]   words_left_q;
  logic [CNT_W-1:0]   match_count_q;
  logic               en_d1_q;
  logic               load_word;
  logic               last_bit;
  logic               abort_act;
  logic               hit;

`ifdef SEQDET_CTRL_ABORT_EN
  assign abort_act = abort && (state_q != S_IDLE);
`else
  assign abort_act = 1'b0;
`endif

  assign last_bit = (bit_cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    det_x     = 1'b0;
    det_en    = 1'b0;
    det_rst   = 1'b0;
    done      = 1'b0;
    load_word = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CLEAR;
      S_CLEAR: begin
        det_rst = 1'b1;
        state_d = (words_left_q == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_word = 1'b1;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        det_x  = shreg_q[WORD_W-1];
        det_en = 1'b1;
        if (last_bit) begin
          if (words_left_q > CNT_W'(1)) begin
            // prefetch the next word so back-to-back words have no bubble
            in_ready = 1'b1;
            if (in_valid) load_word = 1'b1;
            else          state_d   = S_LOAD;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_act) begin
      state_d   = S_IDLE;
      in_ready  = 1'b0;
      det_x     = 1'b0;
      det_en    = 1'b0;
      det_rst   = 1'b1;
      done      = 1'b0;
      load_word = 1'b0;
    end
  end

  // det_y reflects the previous edge, so a hit belongs to the bit clocked one cycle earlier
  assign hit         = en_d1_q && det_y && !abort_act;
  assign match_pulse = hit;
  assign match_count = match_count_q;
  assign busy        = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      words_left_q  <= '0;
      match_count_q <= '0;
      en_d1_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      en_d1_q <= det_en;
      if (state_q == S_IDLE && start) words_left_q <= num_words;
      else if (det_en && last_bit)    words_left_q <= words_left_q - 1'b1;
      if (load_word) begin
        shreg_q   <= in_data;
        bit_cnt_q <= BIT_W'(WORD_W - 1);
      end else if (det_en) begin
        shreg_q   <= shreg_q << 1;
        bit_cnt_q <= bit_cnt_q - 1'b1;
      end
      if (state_q == S_CLEAR && !abort_act) match_count_q <= '0;
      else if (hit && match_count_q != '1)  match_count_q <= match_count_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_seqdet_stream_ctrl.sv
// Directed bench for seqdet_stream_ctrl with a behavioural overlapping 1011 Moore detector.
// A second instance with CNT_W=2 shares the stimulus to exercise count saturation.
module tb_seqdet_stream_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [15:0] num_words;
  logic [7:0]  in_data;
  logic        in_ready, det_x, det_en, det_rst, det_y, match_pulse, busy, done;
  logic [15:0] match_count;
  logic        in_ready_b, det_x_b, det_en_b, det_rst_b, match_pulse_b, busy_b, done_b;
  logic [1:0]  match_count_b;
`ifdef SEQDET_CTRL_ABORT_EN
  logic        abort;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seqdet_stream_ctrl #(.WORD_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .det_x(det_x), .det_en(det_en), .det_rst(det_rst), .det_y(det_y),
    .match_count(match_count), .match_pulse(match_pulse), .busy(busy), .done(done)
`ifdef SEQDET_CTRL_ABORT_EN
    , .abort(abort)
`endif
  );

  seqdet_stream_ctrl #(.WORD_W(8), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words[1:0]),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
    .det_x(det_x_b), .det_en(det_en_b), .det_rst(det_rst_b), .det_y(det_y),
    .match_count(match_count_b), .match_pulse(match_pulse_b), .busy(busy_b), .done(done_b)
`ifdef SEQDET_CTRL_ABORT_EN
    , .abort(abort)
`endif
  );

  // overlapping Moore detector for 1011: 0 none, 1 "1", 2 "10", 3 "101", 4 "1011"
  logic [2:0] ds;
  assign det_y = (ds == 3'd4);
  always @(posedge clk) begin
    if (reset || det_rst) ds <= 3'd0;
    else if (det_en) begin
      case (ds)
        3'd0:    ds <= det_x ? 3'd1 : 3'd0;
        3'd1:    ds <= det_x ? 3'd1 : 3'd2;
        3'd2:    ds <= det_x ? 3'd3 : 3'd0;
        3'd3:    ds <= det_x ? 3'd4 : 3'd2;
        default: ds <= det_x ? 3'd1 : 3'd2;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input int n, input logic [7:0] w0, input logic [7:0] w1,
                     input int gap, input int restart_at, input int exp_done,
                     input int exp_cnt_a, input int exp_cnt_b, input int exp_first);
    logic [7:0] words [2];
    int idx = 0, gap_left = gap, done_at = -1, first_pulse = -1;
    int en_cnt = 0, pulse_cnt = 0, rst_at = -1, rdy_cnt = 0, diff = 0;
    logic [15:0] mc_a = '1;
    logic [1:0]  mc_b = '1;
    words[0] = w0;
    words[1] = w1;
    @(negedge clk);
    start = 1'b1; num_words = 16'(n); in_valid = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 200 && done_at < 0; c++) begin
      @(negedge clk);
      if (done) begin done_at = c; mc_a = match_count; mc_b = match_count_b; end
      if (det_en) en_cnt++;
      if (match_pulse) begin pulse_cnt++; if (first_pulse < 0) first_pulse = c; end
      if (det_rst && rst_at < 0) rst_at = c;
      if (in_ready) rdy_cnt++;
      if ({in_ready, det_x, det_en, det_rst, match_pulse, busy, done} !==
          {in_ready_b, det_x_b, det_en_b, det_rst_b, match_pulse_b, busy_b, done_b}) diff++;
      if (gap > 0 && c == 13) chk({tag, "_gap_en"}, det_en, 0);
      start     = (c == restart_at);
      num_words = 16'd7;
      in_valid  = (idx < n) && (idx < 2) && !(idx == 1 && gap_left > 0);
      in_data   = (idx < 2) ? words[idx] : 8'h00;
      if (in_ready && idx == 1 && gap_left > 0) gap_left--;
      if (in_ready && in_valid) idx++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk({tag, "_done_cycle"}, done_at, exp_done);
    chk({tag, "_count"}, mc_a, exp_cnt_a);
    chk({tag, "_count_sat"}, mc_b, exp_cnt_b);
    chk({tag, "_pulses"}, pulse_cnt, exp_cnt_a);
    chk({tag, "_first_pulse"}, first_pulse, exp_first);
    chk({tag, "_en_cycles"}, en_cnt, 8 * n);
    chk({tag, "_rst_cycle"}, rst_at, 1);
    chk({tag, "_ready_cycles"}, rdy_cnt, n + gap);
    chk({tag, "_inst_diff"}, diff, 0);
    @(negedge clk);
    chk({tag, "_idle_after"}, {busy, done}, 2'b00);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; num_words = '0; in_data = '0; in_valid = 1'b0;
`ifdef SEQDET_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {in_ready, det_x, det_en, det_rst, match_pulse, busy, done}, 7'd0);
    chk("reset_count", match_count, 0);
    reset = 1'b0;
    @(negedge clk);

    run("single",    1, 8'hB6, 8'h00, 0, 0, 12, 2, 2, 7);
    run("boundary",  2, 8'h0B, 8'h60, 0, 0, 20, 2, 2, 11);
    run("underrun",  2, 8'h0B, 8'h60, 5, 0, 25, 2, 2, 11);
    run("zero",      0, 8'h00, 8'h00, 0, 0, 2,  0, 0, -1);
    run("restart",   1, 8'hB6, 8'h00, 0, 5, 12, 2, 2, 7);
    run("saturate",  2, 8'hBB, 8'hBB, 0, 0, 20, 4, 3, 7);

    // reset in the middle of SHIFT
    @(negedge clk);
    start = 1'b1; num_words = 16'd2; in_valid = 1'b1; in_data = 8'h0B;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrun_shifting", det_en, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrun_reset_ctrl", {in_ready, det_x, det_en, det_rst, match_pulse, busy, done}, 7'd0);
    chk("midrun_reset_count", match_count, 0);
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);

`ifdef SEQDET_CTRL_ABORT_EN
    begin
      int done_seen = 0;
      @(negedge clk);
      start = 1'b1; num_words = 16'd1; in_valid = 1'b1; in_data = 8'hB6;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      abort = 1'b1;
      #1;
      chk("abort_det_rst", det_rst, 1);
      chk("abort_ready", in_ready, 0);
      @(negedge clk);
      abort = 1'b0;
      chk("abort_idle", {busy, done}, 2'b00);
      chk("abort_count_hold", match_count, 0);
      for (int k = 0; k < 15; k++) begin
        @(negedge clk);
        if (done || busy) done_seen++;
      end
      chk("abort_no_done", done_seen, 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seqdet_stream_ctrl.md
# seqdet_stream_ctrl

Controller that feeds a serial sequence detector from a word-wide stream. It accepts words over a valid/ready handshake and serializes them MSB-first onto the detector's `x` input. It gates the detector with a bit enable, counts detector hits over a programmed number of words, and reports completion. It sits between a word-oriented producer (host/DMA) and a single-bit sequence-detector instance that has a clock-enable wrapper.

## Interface
- `WORD_W`, 8: bits per input word.
- `CNT_W`, 16: width of the word-count and match-count registers.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a run; sampled only in IDLE.
- `num_words`  in  CNT_W  number of words in the run; latched on accepted `start`.
- `in_data`  in  WORD_W  input word.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  controller accepts `in_data` this cycle.
- `det_x`  out  1  serial bit to the detector; 0 when `det_en`=0.
- `det_en`  out  1  detector advances on this edge only.
- `det_rst`  out  1  one-cycle detector clear at run start.
- `det_y`  in  1  detector Moore output; reflects all bits clocked in up to the previous edge.
- `match_count`  out  CNT_W  hits in the current/last run; saturates at all-ones.
- `match_pulse`  out  1  high in any cycle where a hit is counted.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of a run.

## Operation
- States: IDLE, CLEAR, LOAD, SHIFT, DRAIN, DONE.
- Reset: state IDLE; every output is 0; shift register, bit counter, words_left and match_count are 0.
- IDLE: `start`=1 latches `num_words` into words_left and moves to CLEAR. `start` is ignored in every other state.
- CLEAR (1 cycle): `det_rst`=1 and match_count is cleared to 0.
  - Next state is DONE if words_left==0, otherwise LOAD.
- LOAD: `in_ready`=1 and `det_en`=0. On `in_valid`, capture `in_data`, set bit_cnt=WORD_W-1 and go to SHIFT.
- SHIFT: `det_x`=shreg[MSB], `det_en`=1, shift left and decrement bit_cnt.
  - On the last bit (bit_cnt==0), words_left decrements.
  - If words_left>1 at the last bit, `in_ready`=1 (prefetch). If `in_valid` is also high, the new word loads and SHIFT continues with no bubble. Otherwise go to LOAD.
  - If words_left==1 at the last bit, go to DRAIN.
- DRAIN (1 cycle): samples `det_y` for the final bit. Then go to DONE.
- DONE (1 cycle): `done`=1, then go to IDLE. match_count holds until the next CLEAR.
- Hit counting: en_d1 is `det_en` registered. A hit is counted when en_d1 && `det_y`. match_count increments, saturating at 2^CNT_W-1, and `match_pulse`=1 in that cycle.
- The detector is not cleared between words, so patterns spanning word boundaries are detected.
- Underrun (no `in_valid` in LOAD) stalls the run indefinitely with `det_en`=0. Detector state is preserved.
- `reset` mid-run returns to IDLE immediately with all outputs 0. No `done` is produced.

## Timing
- Take `start` sampled at edge 0 with num_words=N and `in_valid` held high:
  - CLEAR in cycle 1.
  - LOAD in cycle 2; the word is accepted there.
  - Bits appear on `det_x` in cycles 3..8N+2.
  - DRAIN in cycle 8N+3.
  - `done`=1 in cycle 8N+4 (WORD_W=8).
- With num_words=0, `done` comes in cycle 2 and match_count=0.
- `match_pulse` lags the bit that completes a pattern by 1 cycle.
- match_count is final in the `done` cycle.
- Each LOAD stall cycle adds exactly 1 cycle to every later event.

## Configuration
- `SEQDET_CTRL_ABORT_EN` defined: adds input port `abort` (1 bit).
  - `abort`=1 in any state other than IDLE forces `det_rst`=1 in that cycle and returns to IDLE on the next edge.
  - No `done` pulse; match_count holds its value; a pending `in_ready` handshake is not accepted.
  - `abort` is ignored in IDLE.
- Not defined: no `abort` port; a run ends only through DONE or `reset`.

## Test plan
The bench uses a behavioural overlapping Moore detector for pattern 1011, with clock enable `det_en` and clear `det_rst`.
- Single word: N=1, word 8'b1011_0110 → hits after bits 4 and 7; match_count=2; `done` at cycle 12 after `start`.
- Cross-boundary: N=2, words 8'h0B then 8'h60 with `in_valid` always high → no bubble between words; match_count=2 (second hit spans the boundary); `done` at cycle 20.
- Underrun: N=2, `in_valid` dropped for 5 cycles before word 2 → `det_en`=0 during the gap; same match_count as the no-gap run; `done` 5 cycles later.
- Zero / ignore: N=0 → `done` at cycle 2, count 0, `in_ready` never high. `start` pulsed while busy → no effect.
- Saturation / reset: CNT_W=2 with stream 8'hBB,8'hBB → count stops at 3. `reset` asserted mid-SHIFT → next cycle all outputs 0, state IDLE.
- Abort (`SEQDET_CTRL_ABORT_EN`): `abort` in the third SHIFT cycle → `det_rst`=1 that cycle, IDLE next cycle, no `done`.
